ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and access sequencer for the 16 x 8 program/data RAM, whose writes and registered read-data capture both occur on the falling clock edge. It shares the single RAM port between the CPU bus (port C) and the front-panel programmer (port P). It drives address, write data and write enable, and returns read data with a one-cycle acknowledge. Fixed CPU priority with a starvation guard; a program-mode input locks the CPU out while memory is being loaded.

## Interface
- AW, 4: RAM address width
- DW, 8: RAM data width
- STARVE_LIMIT, 4: consecutive contested CPU grants before P is forced through (1..15)

- clk  in  1  system clock; all arbiter logic on rising edge
- reset  in  1  synchronous, active-high
- prog_mode  in  1  1 = CPU requests are never granted
- cpu_req / prg_req  in  1  access request; held with its qualifiers until the matching ack
- cpu_we / prg_we  in  1  1 = write, 0 = read
- cpu_addr / prg_addr  in  AW  target address
- cpu_wdata / prg_wdata  in  DW  write data
- cpu_ack / prg_ack  out  1  one-cycle completion pulse
- cpu_rdata / prg_rdata  out  DW  read data; valid while ack is high, held until the next ack on that port
- ram_a  out  AW  to RAM address
- ram_d  out  DW  to RAM write data
- ram_we  out  1  to RAM write enable
- ram_spo  in  DW  RAM registered read data
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE -> ACCESS -> ACK -> IDLE; every state lasts exactly one cycle except IDLE, which holds while no request is eligible.
- IDLE: requests are sampled at the edge. CPU is eligible iff cpu_req && !prog_mode. P is eligible iff prg_req.
  - Winner selection: P wins if it is the only eligible port, or if both are eligible and streak == STARVE_LIMIT; otherwise CPU wins.
  - On a grant: register winner's addr/wdata/we into ram_a/ram_d/ram_we; record owner; go to ACCESS.
- Streak counter (0..STARVE_LIMIT):
  - Incremented when CPU wins while prg_req is high.
  - Cleared when P wins, and at any IDLE arbitration with prg_req low.
  - Never exceeds STARVE_LIMIT.
- ACCESS: ram_* are stable for the whole cycle, so the RAM acts on the mid-cycle falling edge. At the closing edge:
  - ram_spo is copied into the owner's rdata.
  - Owner's ack is set.
  - ram_we is cleared.
  - FSM goes to ACK.
- ACK: owner's ack is high for this one cycle. At the closing edge ack is cleared and the FSM returns to IDLE. The requester drops or renews req at that same edge.
- Read-before-write: on a write, rdata returns the contents of the location before the write.
- ram_a and ram_d keep their last values outside ACCESS; only ram_we is forced to 0.
- prog_mode is sampled only in IDLE. Raising it during ACCESS/ACK does not abort an in-flight CPU access.
- Requests arriving outside IDLE wait; a req dropped before grant is lost without ack.

## Timing
- Reset values: state IDLE, ram_a 0, ram_d 0, ram_we 0, both acks 0, both rdata 0, streak 0, busy 0.
- Latency: a req sampled at IDLE edge N gives ram_we/ram_a valid from N, RAM action at the falling edge N+0.5, and ack high from edge N+1 to N+2.
- Throughput: one access per 3 cycles for back-to-back requests; the next grant is at edge N+3.
- ack is never high on both ports in the same cycle.
- busy is high from edge N to edge N+2.
- Reset mid-ACCESS: all outputs return to reset values at that edge and no ack is issued. A write whose RAM falling edge already occurred before the reset edge remains committed.
- Reset mid-ACK: the ack is truncated.

## Test plan
- Reset then idle: all outputs 0 and busy 0 for 10 cycles with no requests.
- CPU read addr 4, RAM holding 0xE0: cpu_ack pulses for 1 cycle at grant+1 with cpu_rdata = 0xE0; ram_we stays 0 throughout.
- P write 0x51 to addr 13 (old value 0x00), then P read of addr 13: first prg_rdata = 0x00, second = 0x51; ram_we is high for exactly 1 cycle.
- Both requesters held continuously, STARVE_LIMIT=4: grant order C,C,C,C,P,C,C,C,C,P; exactly 3 cycles between consecutive acks.
- prog_mode=1 with cpu_req and prg_req held: only prg_ack pulses. Dropping prog_mode gives a CPU grant at the next IDLE edge.
- reset asserted during a CPU write ACCESS to addr 14: no cpu_ack, ram_we = 0 at the next edge, FSM back in IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 16x8 RAM port between the CPU bus (port C) and the
// front-panel programmer (port P). CPU has fixed priority, bounded by a
// starvation streak counter; prog_mode locks the CPU out.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arbitrate; hold here while no request is eligible
// ACCESS | ram_* stable; RAM acts on mid-cycle falling edge
// ACK    | owner's ack high for exactly this cycle
module ram_arbiter #(
   parameter int AW           = 4,
   parameter int DW           = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_mode,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          prg_req,
   input  logic          prg_we,
   input  logic [AW-1:0] prg_addr,
   input  logic [DW-1:0] prg_wdata,
   output logic          prg_ack,
   output logic [DW-1:0] prg_rdata,
   output logic [AW-1:0] ram_a,
   output logic [DW-1:0] ram_d,
   output logic          ram_we,
   input  logic [DW-1:0] ram_spo,
   output logic          busy
);

   // Streak counter is 4 bits wide; STARVE_LIMIT is bounded to 1..15.
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ram_a_q, ram_a_d;
   logic [DW-1:0]   ram_d_q, ram_d_d;
   logic            ram_we_q, ram_we_d;
   logic            owner_q, owner_d;      // 0 = CPU, 1 = programmer
   logic            cpu_ack_q, cpu_ack_d;
   logic            prg_ack_q, prg_ack_d;
   logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0]   prg_rdata_q, prg_rdata_d;
   logic [3:0]      streak_q, streak_d;
   logic            cpu_elig;
   logic            prg_elig;

   // Next-state, arbitration and access sequencing.
   always_comb begin
      state_d     = state_q;
      ram_a_d     = ram_a_q;
      ram_d_d     = ram_d_q;
      ram_we_d    = ram_we_q;
      owner_d     = owner_q;
      cpu_ack_d   = cpu_ack_q;
      prg_ack_d   = prg_ack_q;
      cpu_rdata_d = cpu_rdata_q;
      prg_rdata_d = prg_rdata_q;
      streak_d    = streak_q;
      cpu_elig    = cpu_req && !prog_mode;
      prg_elig    = prg_req;

      case (state_q)
         IDLE: begin
            if (!prg_req) begin
               streak_d = 4'd0;
            end
            if (prg_elig && (!cpu_elig || streak_q == LIMIT)) begin
               ram_a_d  = prg_addr;
               ram_d_d  = prg_wdata;
               ram_we_d = prg_we;
               owner_d  = 1'b1;
               streak_d = 4'd0;
               state_d  = ACCESS;
            end else if (cpu_elig) begin
               ram_a_d  = cpu_addr;
               ram_d_d  = cpu_wdata;
               ram_we_d = cpu_we;
               owner_d  = 1'b0;
               if (prg_req && streak_q != LIMIT) begin
                  streak_d = streak_q + 4'd1;
               end
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            // ram_spo already holds the pre-write contents captured mid-cycle.
            if (owner_q) begin
               prg_rdata_d = ram_spo;
               prg_ack_d   = 1'b1;
            end else begin
               cpu_rdata_d = ram_spo;
               cpu_ack_d   = 1'b1;
            end
            ram_we_d = 1'b0;
            state_d  = ACK;
         end
         ACK: begin
            cpu_ack_d = 1'b0;
            prg_ack_d = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ram_a_q     <= '0;
         ram_d_q     <= '0;
         ram_we_q    <= 1'b0;
         owner_q     <= 1'b0;
         cpu_ack_q   <= 1'b0;
         prg_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         prg_rdata_q <= '0;
         streak_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         ram_a_q     <= ram_a_d;
         ram_d_q     <= ram_d_d;
         ram_we_q    <= ram_we_d;
         owner_q     <= owner_d;
         cpu_ack_q   <= cpu_ack_d;
         prg_ack_q   <= prg_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         prg_rdata_q <= prg_rdata_d;
         streak_q    <= streak_d;
      end
   end

   assign ram_a     = ram_a_q;
   assign ram_d     = ram_d_q;
   assign ram_we    = ram_we_q;
   assign cpu_ack   = cpu_ack_q;
   assign prg_ack   = prg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign prg_rdata = prg_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a falling-edge 16x8 RAM model.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       prog_mode = 1'b0;
   logic       cpu_req = 1'b0, cpu_we = 1'b0;
   logic [3:0] cpu_addr = '0;
   logic [7:0] cpu_wdata = '0;
   logic       prg_req = 1'b0, prg_we = 1'b0;
   logic [3:0] prg_addr = '0;
   logic [7:0] prg_wdata = '0;
   logic       cpu_ack, prg_ack, ram_we, busy;
   logic [7:0] cpu_rdata, prg_rdata, ram_d;
   logic [3:0] ram_a;
   logic [7:0] ram_spo = '0;
   logic [7:0] mem [16];

   int total = 0;
   int bad   = 0;

   ram_arbiter #(.AW(4), .DW(8), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .prog_mode(prog_mode),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
      .prg_ack(prg_ack), .prg_rdata(prg_rdata),
      .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM: registered read and write both on the falling edge (read-before-write).
   always @(negedge clk) begin
      ram_spo <= mem[ram_a];
      if (ram_we) mem[ram_a] <= ram_d;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One uncontested access from IDLE; p selects the programmer port.
   task automatic access(input bit p, input bit we, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd);
      if (p) begin
         prg_req = 1'b1; prg_we = we; prg_addr = a; prg_wdata = d;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
      tick();
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_ram_a", 32'(ram_a), 32'(a));
      chk("acc_ram_we", 32'(ram_we), 32'(we));
      if (we) chk("acc_ram_d", 32'(ram_d), 32'(d));
      chk("acc_ack_early", 32'({cpu_ack, prg_ack}), 32'd0);
      tick();
      chk("acc_ack", 32'({cpu_ack, prg_ack}), p ? 32'd1 : 32'd2);
      chk("acc_rdata", 32'(p ? prg_rdata : cpu_rdata), 32'(exp_rd));
      chk("acc_we_clr", 32'(ram_we), 32'd0);
      chk("acc_busy2", 32'(busy), 32'd1);
      cpu_req = 1'b0; prg_req = 1'b0;
      tick();
      chk("acc_ack_end", 32'({cpu_ack, prg_ack}), 32'd0);
      chk("acc_idle", 32'(busy), 32'd0);
      chk("acc_rdata_hold", 32'(p ? prg_rdata : cpu_rdata), 32'(exp_rd));
   endtask

   initial begin
      logic exp_p [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int n, last, pc, cc;

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[4] = 8'hE0;

      // Reset then idle.
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_ctrl", 32'({busy, cpu_ack, prg_ack, ram_we}), 32'd0);
         chk("idle_data", 32'({ram_a, ram_d, cpu_rdata, prg_rdata}), 32'd0);
      end

      // CPU read of addr 4.
      access(1'b0, 1'b0, 4'd4, 8'h00, 8'hE0);

      // Programmer write then read-back of addr 13.
      access(1'b1, 1'b1, 4'd13, 8'h51, 8'h00);
      chk("mem13", 32'(mem[13]), 32'h51);
      access(1'b1, 1'b0, 4'd13, 8'h00, 8'h51);

      // Both requesters held: starvation guard lets P through every 5th grant.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd4;
      prg_req = 1'b1; prg_we = 1'b0; prg_addr = 4'd13;
      n = 0; last = 0;
      for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
         tick();
         chk("ack_excl", 32'(cpu_ack && prg_ack), 32'd0);
         if (cpu_ack || prg_ack) begin
            chk($sformatf("order%0d", n), 32'(prg_ack), 32'(exp_p[n]));
            if (n > 0) chk("ack_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            n++;
            if (n == 10) begin
               cpu_req = 1'b0; prg_req = 1'b0;
            end
         end
      end
      chk("starve_acks", 32'(n), 32'd10);
      tick();
      chk("starve_idle", 32'(busy), 32'd0);

      // prog_mode locks the CPU out.
      prog_mode = 1'b1;
      cpu_req = 1'b1; prg_req = 1'b1;
      pc = 0; cc = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         pc += int'(prg_ack);
         cc += int'(cpu_ack);
      end
      chk("pm_prg_acks", 32'(pc), 32'd3);
      chk("pm_cpu_acks", 32'(cc), 32'd0);
      prog_mode = 1'b0;
      tick();
      chk("pm_rel_grant_a", 32'(ram_a), 32'd4);
      chk("pm_rel_busy", 32'(busy), 32'd1);
      tick();
      chk("pm_rel_ack", 32'({cpu_ack, prg_ack}), 32'd2);
      cpu_req = 1'b0; prg_req = 1'b0;
      tick();
      tick();
      chk("pm_end_idle", 32'(busy), 32'd0);

      // Reset during a CPU write ACCESS to addr 14.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd14; cpu_wdata = 8'hAA;
      tick();
      chk("rst_grant_we", 32'(ram_we), 32'd1);
      chk("rst_grant_a", 32'(ram_a), 32'd14);
      reset = 1'b1;
      tick();
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'({cpu_ack, prg_ack}), 32'd0);
      chk("rst_data", 32'({ram_a, ram_d, cpu_rdata, prg_rdata}), 32'd0);
      reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_no_ack", 32'({cpu_ack, prg_ack, busy}), 32'd0);
      end
      chk("rst_committed", 32'(mem[14]), 32'hAA);
      access(1'b0, 1'b0, 4'd14, 8'h00, 8'hAA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
